// File: rtl/sum_tally_pkg.sv
// Shared constants for the sum_tally histogram block: parameter defaults,
// FSM state encodings and common field types.
package sum_tally_pkg;

  localparam int BIN_BASE_DEF = 2;
  localparam int NUM_BINS_DEF = 11;
  localparam int CNT_W_DEF    = 16;
  localparam int TRIALS_DEF   = 1000;

  localparam int SEL_W = 4;

  typedef logic [7:0]       data_t;
  typedef logic [SEL_W-1:0] sel_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_CLEAR = 2'd3;

endpackage

// File: rtl/sum_tally_if.sv
// Sample stream from the upstream sum_3 stage: valid/data forward, ready back.
interface sum_tally_if;
  import sum_tally_pkg::*;

  logic  in_valid;
  data_t in_data;
  logic  in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/sum_tally_mode_tracker.sv
// Tracks the largest bin count seen so far and the index of the bin that
// first reached it; ties keep the earlier winner.
module mode_tracker
  import sum_tally_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             upd,
  input  sel_t             upd_idx,
  input  logic [CNT_W-1:0] upd_cnt,
  output sel_t             mode_bin
);

  logic [CNT_W-1:0] max_q, max_d;
  sel_t             mode_q, mode_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    max_d  = max_q;
    mode_d = mode_q;
    if (clear) begin
      max_d  = '0;
      mode_d = '0;
    end else if (upd && (upd_cnt > max_q)) begin
      max_d  = upd_cnt;
      mode_d = upd_idx;
    end
  end

  // NOTE: state is updated only with non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q  <= '0;
      mode_q <= '0;
    end else begin
      max_q  <= max_d;
      mode_q <= mode_d;
    end
  end

  assign mode_bin = mode_q;

endmodule

// File: rtl/sum_tally.sv
// Histogram of sum_3 results: tallies samples into NUM_BINS saturating bins
// until TRIALS in-range samples are counted, with sweep clear and readout.
module sum_tally
  import sum_tally_pkg::*;
#(
  parameter int BIN_BASE = BIN_BASE_DEF,
  parameter int NUM_BINS = NUM_BINS_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int TRIALS   = TRIALS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  sum_tally_if.slave       bus,
  input  sel_t             sel,
  output logic [CNT_W-1:0] bin_count,
  output logic [CNT_W-1:0] total,
  output sel_t             mode_bin,
  output logic             done,
  output logic             range_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] bins_q [NUM_BINS];
  logic [CNT_W-1:0] bins_d [NUM_BINS];
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] bin_count_q, bin_count_d;
  logic             range_err_q, range_err_d;
  sel_t             clr_idx_q, clr_idx_d;

  logic             in_ready;
  logic             accept;
  logic             in_range;
  logic             hit;
  int               offset;
  sel_t             hit_idx;
  logic [CNT_W-1:0] hit_cnt;

  // Clear wins over a coincident handshake; that sample is dropped.
  always_comb begin
    in_ready = (state_q == ST_RUN);
    offset   = int'(bus.in_data) - BIN_BASE;
    in_range = (offset >= 0) && (offset < NUM_BINS);
    accept   = bus.in_valid && in_ready && !clear;
    hit      = accept && in_range;
  end

  assign bus.in_ready = in_ready;

  always_comb begin
    state_d     = state_q;
    bins_d      = bins_q;
    total_d     = total_q;
    range_err_d = range_err_q;
    clr_idx_d   = clr_idx_q;
    hit_idx     = '0;
    hit_cnt     = '0;

    for (int i = 0; i < NUM_BINS; i++) begin
      if (hit && (offset == i)) begin
        hit_idx   = sel_t'(i);
        hit_cnt   = (bins_q[i] == CNT_MAX) ? bins_q[i] : bins_q[i] + 1'b1;
        bins_d[i] = hit_cnt;
      end
    end
    if (hit && (total_q != CNT_MAX))
      total_d = total_q + 1'b1;
    if (accept && !in_range)
      range_err_d = 1'b1;

    if (clear) begin
      state_d     = ST_CLEAR;
      clr_idx_d   = '0;
      total_d     = '0;
      range_err_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) state_d = ST_RUN;
        ST_RUN: begin
          if (hit && (int'(total_d) == TRIALS)) state_d = ST_DONE;
          else if (!start)                      state_d = ST_IDLE;
        end
        ST_DONE: state_d = ST_DONE;
        ST_CLEAR: begin
          for (int i = 0; i < NUM_BINS; i++)
            if (i == int'(clr_idx_q)) bins_d[i] = '0;
          if (int'(clr_idx_q) == NUM_BINS - 1) state_d = ST_IDLE;
          else                                 clr_idx_d = clr_idx_q + 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Readout is registered; unmapped selects read as zero.
  always_comb begin
    bin_count_d = '0;
    for (int i = 0; i < NUM_BINS; i++)
      if (i == int'(sel)) bin_count_d = bins_q[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      total_q     <= '0;
      bin_count_q <= '0;
      range_err_q <= 1'b0;
      clr_idx_q   <= '0;
      // NOTE: the bin array is reset too, since reset must zero every tally at once, so it stays in flops, not RAM.
      for (int i = 0; i < NUM_BINS; i++) bins_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      bin_count_q <= bin_count_d;
      range_err_q <= range_err_d;
      clr_idx_q   <= clr_idx_d;
      for (int i = 0; i < NUM_BINS; i++) bins_q[i] <= bins_d[i];
    end
  end

  mode_tracker #(.CNT_W(CNT_W)) u_mode (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .upd      (hit),
    .upd_idx  (hit_idx),
    .upd_cnt  (hit_cnt),
    .mode_bin (mode_bin)
  );

  assign bin_count = bin_count_q;
  assign total     = total_q;
  assign done      = (state_q == ST_DONE);
  assign range_err = range_err_q;

endmodule
